// File: rtl/boron_iter_if.sv
// Handshake bundle for boron_iter_core: block/key in, ciphertext out.
// master = upstream/downstream environment, slave = the core.
interface boron_iter_if #(
    parameter int unsigned KEY_W = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      plain_txt;
    logic [KEY_W-1:0] key_in;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      cipher_txt;

    modport master (
        output in_valid, plain_txt, key_in, out_ready,
        input  in_ready, out_valid, cipher_txt
    );

    modport slave (
        input  in_valid, plain_txt, key_in, out_ready,
        output in_ready, out_valid, cipher_txt
    );
endinterface

// File: rtl/boron_iter_core.sv
// Iterative BORON block encryptor: one round per cycle, 80/128-bit key schedule,
// valid/ready on both sides, ciphertext held until the consumer takes it.
module boron_iter_core #(
    parameter int unsigned ROUNDS = 25,
    parameter int unsigned KEY_W  = 128
) (
    input  logic              clk,
    input  logic              reset,
    boron_iter_if.slave       bus,
    output logic              busy,
    output logic [4:0]        round_cnt
);

    localparam int unsigned BLK_W = 64;
    localparam int unsigned CNT_W = 5;

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("boron_iter_core: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("boron_iter_core: ROUNDS must be in 1..31");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // 4-bit BORON S-box
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
            4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
            4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] sub_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    // Each 16-bit lane {n3,n2,n1,n0} becomes {n1,n0,n3,n2}
    function automatic logic [BLK_W-1:0] block_shuffle(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        for (int l = 0; l < 4; l++) begin
            y[16*l +: 16] = {x[16*l +: 8], x[16*l+8 +: 8]};
        end
        return y;
    endfunction

    // Lane rotations: lane0 <<<1, lane1 <<<4, lane2 <<<7, lane3 <<<9
    function automatic logic [BLK_W-1:0] round_p(input logic [BLK_W-1:0] x);
        logic [15:0] w0, w1, w2, w3;
        w0 = x[15:0];
        w1 = x[31:16];
        w2 = x[47:32];
        w3 = x[63:48];
        return {{w3[6:0], w3[15:7]}, {w2[8:0], w2[15:9]},
                {w1[11:0], w1[15:12]}, {w0[14:0], w0[15]}};
    endfunction

    // Lane mixing; lane3 folds in the already-updated lane0
    function automatic logic [BLK_W-1:0] boron_xor(input logic [BLK_W-1:0] x);
        logic [15:0] y0, y1, y2, y3;
        y0 = x[15:0]  ^ x[31:16];
        y1 = x[31:16] ^ x[47:32];
        y2 = x[47:32] ^ x[63:48];
        y3 = x[63:48] ^ y0;
        return {y3, y2, y1, y0};
    endfunction

    function automatic logic [KEY_W-1:0] key_sched(input logic [KEY_W-1:0] k,
                                                   input logic [CNT_W-1:0] rc);
        logic [KEY_W-1:0] r;
        r = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
        r[3:0] = sbox4(r[3:0]);
        if (KEY_W == 128) begin
            r[7:4] = sbox4(r[7:4]);
        end
        r[63:59] = r[63:59] ^ rc;
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   st_q, st_d;
    logic [KEY_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   round_cnt_q, round_cnt_d;
    logic [BLK_W-1:0]   cipher_q, cipher_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [BLK_W-1:0]   round_out;
    logic [KEY_W-1:0]   k_next;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        k_d         = k_q;
        round_cnt_d = round_cnt_q;
        cipher_d    = cipher_q;

        round_out = boron_xor(round_p(block_shuffle(sub_layer(st_q ^ k_q[BLK_W-1:0]))));
        k_next    = key_sched(k_q, round_cnt_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d        = bus.plain_txt;
                    k_d         = bus.key_in;
                    round_cnt_d = CNT_W'(1);
                    state_d     = RUN;
                end
            end
            RUN: begin
                st_d        = round_out;
                k_d         = k_next;
                round_cnt_d = round_cnt_q + CNT_W'(1);
                // Final round: whiten with the post-schedule key
                if (round_cnt_q == CNT_W'(ROUNDS)) begin
                    cipher_d    = round_out ^ k_next[BLK_W-1:0];
                    round_cnt_d = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            st_q        <= '0;
            k_q         <= '0;
            round_cnt_q <= '0;
            cipher_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            k_q         <= k_d;
            round_cnt_q <= round_cnt_d;
            cipher_q    <= cipher_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.cipher_txt = cipher_q;
    assign busy           = busy_q;
    assign round_cnt      = round_cnt_q;

endmodule

// File: tb/tb_boron_iter_core.sv
// Directed bench for boron_iter_core: a 128-bit/25-round instance and an
// 80-bit/1-round instance, checked against hand values and a bit-level model.
module tb_boron_iter_core;

    localparam int unsigned R_A  = 25;
    localparam int unsigned KW_A = 128;
    localparam int unsigned R_B  = 1;
    localparam int unsigned KW_B = 80;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    boron_iter_if #(.KEY_W(KW_A)) bus_a ();
    boron_iter_if #(.KEY_W(KW_B)) bus_b ();
    logic       busy_a, busy_b;
    logic [4:0] rc_a, rc_b;

    boron_iter_core #(.ROUNDS(R_A), .KEY_W(KW_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .round_cnt(rc_a)
    );
    boron_iter_core #(.ROUNDS(R_B), .KEY_W(KW_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .round_cnt(rc_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, written bit/nibble-wise from the algorithm description
    function automatic logic [3:0] ref_sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h6358_F02D_AC97_1B4E;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        logic [15:0] y;
        for (int b = 0; b < 16; b++) y[(b + n) % 16] = x[b];
        return y;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] pt, input logic [127:0] key,
                                          input int kw, input int rounds);
        logic [127:0] k;
        logic [63:0]  st, x;
        logic [15:0]  w [4];
        logic [15:0]  v [4];
        int           rot [4];
        rot = '{1, 4, 7, 9};
        k = key;
        if (kw == 80) k[127:80] = '0;
        st = pt;
        for (int r = 1; r <= rounds; r++) begin
            x = st ^ k[63:0];
            for (int n = 0; n < 16; n++) x[4*n +: 4] = ref_sbox(x[4*n +: 4]);
            for (int l = 0; l < 4; l++) begin
                w[l] = x[16*l +: 16];
                v[l] = rotl16({w[l][7:0], w[l][15:8]}, rot[l]);
            end
            w[0] = v[0] ^ v[1];
            w[1] = v[1] ^ v[2];
            w[2] = v[2] ^ v[3];
            w[3] = v[3] ^ w[0];
            if (kw == 128) k = {k[114:0], k[127:115]};
            else           k = {48'h0, k[66:0], k[79:67]};
            k[3:0] = ref_sbox(k[3:0]);
            if (kw == 128) k[7:4] = ref_sbox(k[7:4]);
            k[63:59] = k[63:59] ^ 5'(r);
            st = {w[3], w[2], w[1], w[0]};
            if (r == rounds) st = st ^ k[63:0];
        end
        return st;
    endfunction

    // Called at the first falling edge after acceptance (lat0 edges already elapsed)
    task automatic wait_out_a(input int lat0, input bit trace, output int lat);
        lat = lat0;
        while (!bus_a.out_valid && lat < int'(R_A) + 10) begin
            if (trace) begin
                check_eq("a_round_cnt", 64'(rc_a), 64'(lat + 1));
                check_eq("a_busy", 64'(busy_a), 64'd1);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_a(input logic [63:0] exp, input int lat0, input bit trace);
        int lat;
        wait_out_a(lat0, trace, lat);
        check_eq("a_latency", 64'(lat), 64'(R_A));
        check_eq("a_cipher", bus_a.cipher_txt, exp);
        if (trace) check_eq("a_rc_done", 64'(rc_a), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_a(input logic [63:0] pt, input logic [127:0] key, input bit trace);
        check_eq("a_in_ready", 64'(bus_a.in_ready), 64'd1);
        bus_a.in_valid  = 1'b1;
        bus_a.plain_txt = pt;
        bus_a.key_in    = key;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        finish_a(model(pt, key, 128, R_A), 0, trace);
    endtask

    task automatic run_b(input logic [63:0] pt, input logic [79:0] key, input logic [63:0] exp);
        int lat;
        check_eq("b_in_ready", 64'(bus_b.in_ready), 64'd1);
        bus_b.in_valid  = 1'b1;
        bus_b.plain_txt = pt;
        bus_b.key_in    = key;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        check_eq("b_round_cnt", 64'(rc_b), 64'd1);
        lat = 0;
        while (!bus_b.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b_latency", 64'(lat), 64'(R_B));
        check_eq("b_cipher", bus_b.cipher_txt, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0]  pt1, pt2, exp1, exp2;
        logic [127:0] k1, k2;
        logic [79:0]  kb;
        int           lat, prev;

        reset           = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.out_ready = 1'b1;
        pt1             = {$urandom, $urandom};
        k1              = {$urandom, $urandom, $urandom, $urandom};
        bus_a.plain_txt = pt1;
        bus_a.key_in    = k1;
        bus_b.in_valid  = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_b.plain_txt = {$urandom, $urandom};
        bus_b.key_in    = {$urandom, $urandom, $urandom};

        // Held in reset with in_valid high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_cipher", bus_a.cipher_txt, 64'h0);
            check_eq("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
            check_eq("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
            check_eq("rst_round_cnt", 64'(rc_a), 64'd0);
            check_eq("rst_busy", 64'(busy_a), 64'd0);
        end
        check_eq("rst_b_cipher", bus_b.cipher_txt, 64'h0);
        check_eq("rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
        reset          = 1'b0;
        bus_b.in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_accept_busy", 64'(busy_a), 64'd1);
        check_eq("post_rst_accept_rc", 64'(rc_a), 64'd1);
        check_eq("post_rst_in_ready", 64'(bus_a.in_ready), 64'd0);
        bus_a.in_valid = 1'b0;
        finish_a(model(pt1, k1, 128, R_A), 0, 1'b0);
        @(negedge clk);

        // Golden directed vectors, 128-bit key, 25 rounds
        run_a(64'h0, 128'h0, 1'b1);
        run_a(64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}}, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            run_a({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        // 80-bit key, single round: zero vector computed by hand
        run_b(64'h0, 80'h0, 64'hE6EE_AAAA_9999_333D);
        run_b(64'hFFFF_FFFF_FFFF_FFFF, {80{1'b1}},
              model(64'hFFFF_FFFF_FFFF_FFFF, {48'h0, {80{1'b1}}}, 80, R_B));
        for (int i = 0; i < 20; i++) begin
            pt1 = {$urandom, $urandom};
            kb  = {$urandom, $urandom, $urandom};
            run_b(pt1, kb, model(pt1, {48'h0, kb}, 80, R_B));
        end

        // Backpressure with a competing block on the input
        pt1 = {$urandom, $urandom};  k1 = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom};  k2 = {$urandom, $urandom, $urandom, $urandom};
        exp1 = model(pt1, k1, 128, R_A);
        exp2 = model(pt2, k2, 128, R_A);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.plain_txt = pt1;
        bus_a.key_in    = k1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        wait_out_a(0, 1'b0, lat);
        check_eq("bp_latency", 64'(lat), 64'(R_A));
        check_eq("bp_cipher", bus_a.cipher_txt, exp1);
        bus_a.in_valid  = 1'b1;
        bus_a.plain_txt = pt2;
        bus_a.key_in    = k2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_hold_cipher", bus_a.cipher_txt, exp1);
            check_eq("bp_hold_valid", 64'(bus_a.out_valid), 64'd1);
            check_eq("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
            check_eq("bp_busy", 64'(busy_a), 64'd0);
        end
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 64'(bus_a.in_ready), 64'd1);
        check_eq("bp_release_valid", 64'(bus_a.out_valid), 64'd0);
        @(negedge clk);
        check_eq("bp_new_accepted", 64'(busy_a), 64'd1);
        check_eq("bp_new_rc", 64'(rc_a), 64'd1);
        bus_a.in_valid = 1'b0;
        finish_a(exp2, 0, 1'b0);

        // Inputs change mid-run
        pt1 = {$urandom, $urandom};  k1 = {$urandom, $urandom, $urandom, $urandom};
        bus_a.in_valid  = 1'b1;
        bus_a.plain_txt = pt1;
        bus_a.key_in    = k1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("dist_rc10", 64'(rc_a), 64'd10);
        bus_a.plain_txt = ~pt1;
        bus_a.key_in    = {$urandom, $urandom, $urandom, $urandom};
        finish_a(model(pt1, k1, 128, R_A), 9, 1'b0);

        // Reset at round 10 aborts the block silently
        bus_a.in_valid  = 1'b1;
        bus_a.plain_txt = {$urandom, $urandom};
        bus_a.key_in    = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("abort_rc10", 64'(rc_a), 64'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_in_ready", 64'(bus_a.in_ready), 64'd1);
        check_eq("abort_rc", 64'(rc_a), 64'd0);
        check_eq("abort_cipher", bus_a.cipher_txt, 64'h0);
        for (int i = 0; i < int'(R_A) + 5; i++) begin
            @(negedge clk);
            check_eq("abort_no_valid", 64'(bus_a.out_valid), 64'd0);
        end
        run_a({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

        // Back-to-back with in_valid and out_ready held high
        bus_a.in_valid = 1'b1;
        prev = 0;
        for (int b = 0; b < 50; b++) begin
            pt1 = {$urandom, $urandom};
            k1  = {$urandom, $urandom, $urandom, $urandom};
            check_eq("b2b_in_ready", 64'(bus_a.in_ready), 64'd1);
            bus_a.plain_txt = pt1;
            bus_a.key_in    = k1;
            if (b > 0) check_eq("b2b_spacing", 64'(cyc - prev), 64'(R_A + 2));
            prev = cyc;
            @(negedge clk);
            wait_out_a(0, 1'b0, lat);
            check_eq("b2b_latency", 64'(lat), 64'(R_A));
            check_eq("b2b_cipher", bus_a.cipher_txt, model(pt1, k1, 128, R_A));
            @(negedge clk);
        end
        bus_a.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
